qp_decoding_pipe: RTL and testbench

Parametrised QP decoder for high-bit-depth H.264 streams.
- Tracks QP'Y across a slice, with correct modulo wrap on mb_qp_delta.
- Derives independent QP'Cb and QP'Cr.
- Keeps a per-MB-column QP'Y row buffer, so the deblocking filter receives the current, left and top QPs plus the averaged qPav values.
- Sits between the slice/MB syntax parsers and the inverse-quantiser/deblocking stages.

---
 rtl/qp_pkg.sv | 31 +++
 rtl/qp_chroma_map.sv | 38 +++
 rtl/qp_decoding_pipe.sv | 150 +++++++++++++++
 tb/tb_qp_decoding_pipe.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/qp_pkg.sv
// rtl/qp_pkg.sv - shared widths and QP helper functions for the QP decoding pipe
package qp_pkg;

    // Width of every QP' value (QP'Y max is 51 + 36 = 87).
    localparam int QP_W    = 7;
    // Signed input widths.
    localparam int SLICE_W = 7;   // pic_init_qp_minus26, slice_qp_delta
    localparam int DELTA_W = 8;   // mb_qp_delta
    localparam int OFFS_W  = 5;   // chroma qp index offsets

    function automatic int qp_bd_offset(input int bitdepth);
        return 6 * (bitdepth - 8);
    endfunction

    // Chroma QP mapping for qPi in 0..51; values below 30 pass through.
    function automatic logic [5:0] chroma_qp_table(input logic [5:0] qpi);
        logic [5:0] r;
        if (qpi < 6'd30)       r = qpi;
        else if (qpi <= 6'd32) r = qpi - 6'd1;
        else if (qpi <= 6'd34) r = 6'd32;
        else if (qpi == 6'd35) r = 6'd33;
        else if (qpi <= 6'd37) r = 6'd34;
        else if (qpi <= 6'd39) r = 6'd35;
        else if (qpi <= 6'd41) r = 6'd36;
        else if (qpi <= 6'd44) r = 6'd37;
        else if (qpi <= 6'd47) r = 6'd38;
        else                   r = 6'd39;
        return r;
    endfunction

endpackage

// File: rtl/qp_chroma_map.sv
// rtl/qp_chroma_map.sv - combinational QP'Y + offset to QP'C mapper for one chroma component
module qp_chroma_map
    import qp_pkg::*;
#(
    parameter int BIT_DEPTH_Y = 8,
    parameter int BIT_DEPTH_C = 8
) (
    input  logic [QP_W-1:0]   qpy_prime_i,
    input  logic [OFFS_W-1:0] offset_i,
    output logic [QP_W-1:0]   qpc_prime_o
);

    localparam logic signed [8:0] OFF_Y_S = 9'(qp_bd_offset(BIT_DEPTH_Y));
    localparam logic signed [8:0] OFF_C_S = 9'(qp_bd_offset(BIT_DEPTH_C));

    logic signed [8:0] qpy_s;
    logic signed [8:0] sum_s;
    logic signed [8:0] qpi_s;
    logic signed [8:0] qpc_s;

    // Remove luma bit-depth offset, add chroma offset, clip, map, re-offset.
    always_comb begin
        qpy_s = $signed({2'b00, qpy_prime_i}) - OFF_Y_S;
        sum_s = qpy_s + $signed({{(9-OFFS_W){offset_i[OFFS_W-1]}}, offset_i});
        if (sum_s < -OFF_C_S)
            qpi_s = -OFF_C_S;
        else if (sum_s > 9'sd51)
            qpi_s = 9'sd51;
        else
            qpi_s = sum_s;
        if (qpi_s < 9'sd30)
            qpc_s = qpi_s;
        else
            qpc_s = $signed({3'b000, chroma_qp_table(qpi_s[5:0])});
        qpc_prime_o = QP_W'(qpc_s + OFF_C_S);
    end

endmodule

// File: rtl/qp_decoding_pipe.sv
// rtl/qp_decoding_pipe.sv - slice QP tracker with chroma mapping and row-buffered neighbour QPs (option: SEPARATE_CR_OFFSET_EN)
module qp_decoding_pipe
    import qp_pkg::*;
#(
    parameter int BIT_DEPTH_Y = 8,
    parameter int BIT_DEPTH_C = 8,
    parameter int MAX_MB_W    = 120,
    parameter int MBX_W       = 7
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                slice_start,
    input  logic [SLICE_W-1:0]  pic_init_qp_minus26,
    input  logic [SLICE_W-1:0]  slice_qp_delta,
    input  logic [OFFS_W-1:0]   cb_qp_offset,
    input  logic [OFFS_W-1:0]   cr_qp_offset,
    input  logic                mb_qp_delta_vld,
    input  logic [DELTA_W-1:0]  mb_qp_delta,
    input  logic                mb_done,
    input  logic [MBX_W-1:0]    mb_x,
    input  logic                left_avail,
    input  logic                top_avail,
    output logic                out_valid,
    output logic [QP_W-1:0]     qpy_out,
    output logic [QP_W-1:0]     qpcb_out,
    output logic [QP_W-1:0]     qpcr_out,
    output logic [QP_W-1:0]     qpy_left,
    output logic [QP_W-1:0]     qpy_top,
    output logic [QP_W-1:0]     qpav_left,
    output logic [QP_W-1:0]     qpav_top
);

    localparam int OFF_Y = qp_bd_offset(BIT_DEPTH_Y);
    localparam logic signed [9:0] OFF_Y_S10 = 10'(OFF_Y);
    localparam logic signed [9:0] MAXQ_S10  = 10'(52 + OFF_Y - 1);
    localparam logic signed [8:0] MOD_S9    = 9'(52 + OFF_Y);
    localparam logic [MBX_W:0]    MAX_X     = (MBX_W+1)'(MAX_MB_W);

    logic [QP_W-1:0] qpy_q, qpy_d;
    logic [QP_W-1:0] left_q;
    logic            out_valid_q;
    logic [QP_W-1:0] qpy_out_q, qpcb_q, qpcr_q, left_out_q, top_out_q, av_left_q, av_top_q;
    logic [QP_W-1:0] row_buf [MAX_MB_W];

    logic signed [9:0] slice_sum;
    logic signed [8:0] delta_sum;
    logic [QP_W-1:0]   slice_qp, delta_qp;
    logic              x_in_range;
    logic [QP_W-1:0]   left_nb, top_nb;
    logic [QP_W-1:0]   qpcb_c, qpcr_c;

    // Slice QP load with clamp, and mb_qp_delta with single modulo correction.
    always_comb begin
        slice_sum = 10'sd26
                  + $signed({{(10-SLICE_W){pic_init_qp_minus26[SLICE_W-1]}}, pic_init_qp_minus26})
                  + $signed({{(10-SLICE_W){slice_qp_delta[SLICE_W-1]}}, slice_qp_delta})
                  + OFF_Y_S10;
        if (slice_sum < 10'sd0)
            slice_qp = '0;
        else if (slice_sum > MAXQ_S10)
            slice_qp = QP_W'(MAXQ_S10);
        else
            slice_qp = QP_W'(slice_sum);

        delta_sum = $signed({2'b00, qpy_q}) + $signed({mb_qp_delta[DELTA_W-1], mb_qp_delta});
        if (delta_sum < 9'sd0)
            delta_qp = QP_W'(delta_sum + MOD_S9);
        else if (delta_sum >= MOD_S9)
            delta_qp = QP_W'(delta_sum - MOD_S9);
        else
            delta_qp = QP_W'(delta_sum);
    end

    // Effective QP'Y this cycle: slice load wins over the delta.
    always_comb begin
        qpy_d = qpy_q;
        if (slice_start)
            qpy_d = slice_qp;
        else if (mb_qp_delta_vld)
            qpy_d = delta_qp;
    end

    assign x_in_range = {1'b0, mb_x} < MAX_X;
    assign left_nb    = left_avail ? left_q : qpy_d;
    assign top_nb     = (top_avail && x_in_range) ? row_buf[mb_x] : qpy_d;

    qp_chroma_map #(.BIT_DEPTH_Y(BIT_DEPTH_Y), .BIT_DEPTH_C(BIT_DEPTH_C)) u_map_cb (
        .qpy_prime_i (qpy_d),
        .offset_i    (cb_qp_offset),
        .qpc_prime_o (qpcb_c)
    );

`ifdef SEPARATE_CR_OFFSET_EN
    qp_chroma_map #(.BIT_DEPTH_Y(BIT_DEPTH_Y), .BIT_DEPTH_C(BIT_DEPTH_C)) u_map_cr (
        .qpy_prime_i (qpy_d),
        .offset_i    (cr_qp_offset),
        .qpc_prime_o (qpcr_c)
    );
`else
    logic unused_cr_offset;
    assign unused_cr_offset = ^cr_qp_offset;
    assign qpcr_c = qpcb_c;
`endif

    // QP state, left neighbour and the registered result set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            qpy_q       <= '0;
            left_q      <= '0;
            out_valid_q <= 1'b0;
            qpy_out_q   <= '0;
            qpcb_q      <= '0;
            qpcr_q      <= '0;
            left_out_q  <= '0;
            top_out_q   <= '0;
            av_left_q   <= '0;
            av_top_q    <= '0;
        end else begin
            qpy_q       <= qpy_d;
            out_valid_q <= mb_done;
            if (mb_done) begin
                left_q     <= qpy_d;
                qpy_out_q  <= qpy_d;
                qpcb_q     <= qpcb_c;
                qpcr_q     <= qpcr_c;
                left_out_q <= left_nb;
                top_out_q  <= top_nb;
                // Bit-depth offsets cancel, so averaging QP' values equals averaging QPy then re-offsetting.
                av_left_q  <= QP_W'(({1'b0, qpy_d} + {1'b0, left_nb} + 8'd1) >> 1);
                av_top_q   <= QP_W'(({1'b0, qpy_d} + {1'b0, top_nb} + 8'd1) >> 1);
            end
        end
    end

    // Row buffer write after the combinational top read (read returns old data).
    always_ff @(posedge clk) begin
        if (reset_n && mb_done && x_in_range)
            row_buf[mb_x] <= qpy_d;
    end

    assign out_valid = out_valid_q;
    assign qpy_out   = qpy_out_q;
    assign qpcb_out  = qpcb_q;
    assign qpcr_out  = qpcr_q;
    assign qpy_left  = left_out_q;
    assign qpy_top   = top_out_q;
    assign qpav_left = av_left_q;
    assign qpav_top  = av_top_q;

endmodule

// File: tb/tb_qp_decoding_pipe.sv
// tb/tb_qp_decoding_pipe.sv - directed self-checking bench for qp_decoding_pipe at 8-bit and 10-bit depth
module tb_qp_decoding_pipe;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       slice_start;
    logic [6:0] pic_init_qp_minus26;
    logic [6:0] slice_qp_delta;
    logic [4:0] cb_qp_offset;
    logic [4:0] cr_qp_offset;
    logic       mb_qp_delta_vld;
    logic [7:0] mb_qp_delta;
    logic       mb_done;
    logic [6:0] mb_x;
    logic       left_avail;
    logic       top_avail;

    logic       v8, v10;
    logic [6:0] y8, cb8, cr8, l8, t8, al8, at8;
    logic [6:0] y10, cb10, cr10, l10, t10, al10, at10;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qp_decoding_pipe dut8 (
        .clk(clk), .reset_n(reset_n), .slice_start(slice_start),
        .pic_init_qp_minus26(pic_init_qp_minus26), .slice_qp_delta(slice_qp_delta),
        .cb_qp_offset(cb_qp_offset), .cr_qp_offset(cr_qp_offset),
        .mb_qp_delta_vld(mb_qp_delta_vld), .mb_qp_delta(mb_qp_delta),
        .mb_done(mb_done), .mb_x(mb_x), .left_avail(left_avail), .top_avail(top_avail),
        .out_valid(v8), .qpy_out(y8), .qpcb_out(cb8), .qpcr_out(cr8),
        .qpy_left(l8), .qpy_top(t8), .qpav_left(al8), .qpav_top(at8)
    );

    qp_decoding_pipe #(.BIT_DEPTH_Y(10), .BIT_DEPTH_C(10)) dut10 (
        .clk(clk), .reset_n(reset_n), .slice_start(slice_start),
        .pic_init_qp_minus26(pic_init_qp_minus26), .slice_qp_delta(slice_qp_delta),
        .cb_qp_offset(cb_qp_offset), .cr_qp_offset(cr_qp_offset),
        .mb_qp_delta_vld(mb_qp_delta_vld), .mb_qp_delta(mb_qp_delta),
        .mb_done(mb_done), .mb_x(mb_x), .left_avail(left_avail), .top_avail(top_avail),
        .out_valid(v10), .qpy_out(y10), .qpcb_out(cb10), .qpcr_out(cr10),
        .qpy_left(l10), .qpy_top(t10), .qpav_left(al10), .qpav_top(at10)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_slice(input int pic, input int sqd);
        slice_start = 1'b1;
        pic_init_qp_minus26 = 7'(pic);
        slice_qp_delta = 7'(sqd);
        step();
        slice_start = 1'b0;
    endtask

    task automatic do_mb(input int x, input logic la, input logic ta, input logic dv, input int d);
        mb_done = 1'b1;
        mb_x = 7'(x);
        left_avail = la;
        top_avail = ta;
        mb_qp_delta_vld = dv;
        mb_qp_delta = 8'(d);
        step();
        mb_done = 1'b0;
        mb_qp_delta_vld = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        checks++; if (v8 !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%0b expected=0", v8); end
        checks++; if (y8 !== 7'd0) begin failures++; $display("FAIL reset_qpy actual=%0d expected=0", y8); end
        checks++; if (cb8 !== 7'd0) begin failures++; $display("FAIL reset_qpcb actual=%0d expected=0", cb8); end
        checks++; if (at8 !== 7'd0) begin failures++; $display("FAIL reset_qpav_top actual=%0d expected=0", at8); end
        checks++; if (y10 !== 7'd0) begin failures++; $display("FAIL reset_qpy10 actual=%0d expected=0", y10); end
    endtask

    task automatic test_slice_latency();
        load_slice(0, 2);
        checks++; if (v8 !== 1'b0) begin failures++; $display("FAIL lat_pre_valid actual=%0b expected=0", v8); end
        do_mb(0, 1'b0, 1'b0, 1'b0, 0);
        checks++; if (v8 !== 1'b1) begin failures++; $display("FAIL lat_valid actual=%0b expected=1", v8); end
        checks++; if (y8 !== 7'd28) begin failures++; $display("FAIL lat_qpy actual=%0d expected=28", y8); end
        checks++; if (cb8 !== 7'd28) begin failures++; $display("FAIL lat_qpcb actual=%0d expected=28", cb8); end
        checks++; if (l8 !== 7'd28) begin failures++; $display("FAIL lat_left_own actual=%0d expected=28", l8); end
        step();
        checks++; if (v8 !== 1'b0) begin failures++; $display("FAIL lat_pulse actual=%0b expected=0", v8); end
    endtask

    task automatic test_delta_wrap();
        load_slice(24, 0);
        do_mb(0, 1'b0, 1'b0, 1'b1, 5);
        checks++; if (y8 !== 7'd3) begin failures++; $display("FAIL wrap_up actual=%0d expected=3", y8); end
        do_mb(0, 1'b0, 1'b0, 1'b1, -10);
        checks++; if (y8 !== 7'd45) begin failures++; $display("FAIL wrap_down actual=%0d expected=45", y8); end
        checks++; if (cb8 !== 7'd38) begin failures++; $display("FAIL wrap_qpcb actual=%0d expected=38", cb8); end
        do_mb(0, 1'b0, 1'b0, 1'b0, 0);
        checks++; if (y8 !== 7'd45) begin failures++; $display("FAIL keep_qp actual=%0d expected=45", y8); end
        load_slice(63, 63);
        do_mb(0, 1'b0, 1'b0, 1'b0, 0);
        checks++; if (y8 !== 7'd51) begin failures++; $display("FAIL clamp_hi actual=%0d expected=51", y8); end
        checks++; if (cb8 !== 7'd39) begin failures++; $display("FAIL clamp_hi_qpcb actual=%0d expected=39", cb8); end
        load_slice(-64, -64);
        do_mb(0, 1'b0, 1'b0, 1'b0, 0);
        checks++; if (y8 !== 7'd0) begin failures++; $display("FAIL clamp_lo actual=%0d expected=0", y8); end
    endtask

    task automatic test_high_bitdepth();
        cb_qp_offset = 5'(-12);
        load_slice(-38, 0);
        do_mb(0, 1'b0, 1'b0, 1'b0, 0);
        checks++; if (y10 !== 7'd0) begin failures++; $display("FAIL hbd_qpy_min actual=%0d expected=0", y10); end
        checks++; if (cb10 !== 7'd0) begin failures++; $display("FAIL hbd_qpcb_min actual=%0d expected=0", cb10); end
        cb_qp_offset = 5'd12;
        load_slice(25, 0);
        do_mb(0, 1'b0, 1'b0, 1'b0, 0);
        checks++; if (y10 !== 7'd63) begin failures++; $display("FAIL hbd_qpy_max actual=%0d expected=63", y10); end
        checks++; if (cb10 !== 7'd51) begin failures++; $display("FAIL hbd_qpcb_max actual=%0d expected=51", cb10); end
        do_mb(0, 1'b0, 1'b0, 1'b1, 1);
        checks++; if (y10 !== 7'd0) begin failures++; $display("FAIL hbd_wrap actual=%0d expected=0", y10); end
        checks++; if (cb10 !== 7'd12) begin failures++; $display("FAIL hbd_qpcb_wrap actual=%0d expected=12", cb10); end
        checks++; if (y8 !== 7'd0) begin failures++; $display("FAIL bd8_wrap actual=%0d expected=0", y8); end
        cb_qp_offset = 5'd0;
    endtask

    task automatic test_row_buffer();
        load_slice(4, 0);
        do_mb(3, 1'b0, 1'b0, 1'b0, 0);
        checks++; if (y8 !== 7'd30) begin failures++; $display("FAIL row0_qpy actual=%0d expected=30", y8); end
        do_mb(3, 1'b0, 1'b1, 1'b1, -10);
        checks++; if (y8 !== 7'd20) begin failures++; $display("FAIL row1_qpy actual=%0d expected=20", y8); end
        checks++; if (t8 !== 7'd30) begin failures++; $display("FAIL row1_top actual=%0d expected=30", t8); end
        checks++; if (at8 !== 7'd25) begin failures++; $display("FAIL row1_qpav_top actual=%0d expected=25", at8); end
        checks++; if (l8 !== 7'd20) begin failures++; $display("FAIL row1_left_own actual=%0d expected=20", l8); end
        checks++; if (al8 !== 7'd20) begin failures++; $display("FAIL row1_qpav_left actual=%0d expected=20", al8); end
    endtask

    task automatic test_back_to_back();
        do_mb(3, 1'b0, 1'b1, 1'b1, 2);
        checks++; if (v8 !== 1'b1) begin failures++; $display("FAIL b2b_valid1 actual=%0b expected=1", v8); end
        checks++; if (t8 !== 7'd20) begin failures++; $display("FAIL b2b_top actual=%0d expected=20", t8); end
        checks++; if (at8 !== 7'd21) begin failures++; $display("FAIL b2b_qpav_top actual=%0d expected=21", at8); end
        do_mb(4, 1'b1, 1'b0, 1'b1, 2);
        checks++; if (v8 !== 1'b1) begin failures++; $display("FAIL b2b_valid2 actual=%0b expected=1", v8); end
        checks++; if (l8 !== 7'd22) begin failures++; $display("FAIL b2b_left actual=%0d expected=22", l8); end
        checks++; if (al8 !== 7'd23) begin failures++; $display("FAIL b2b_qpav_left actual=%0d expected=23", al8); end
        checks++; if (t8 !== 7'd24) begin failures++; $display("FAIL b2b_top_own actual=%0d expected=24", t8); end
        do_mb(125, 1'b0, 1'b1, 1'b0, 0);
        checks++; if (t8 !== 7'd24) begin failures++; $display("FAIL oob_top actual=%0d expected=24", t8); end
        checks++; if (at8 !== 7'd24) begin failures++; $display("FAIL oob_qpav_top actual=%0d expected=24", at8); end
    endtask

    task automatic test_priority_and_reset();
        slice_start = 1'b1;
        pic_init_qp_minus26 = 7'd0;
        slice_qp_delta = 7'(-6);
        mb_qp_delta_vld = 1'b1;
        mb_qp_delta = 8'd10;
        step();
        slice_start = 1'b0;
        mb_qp_delta_vld = 1'b0;
        do_mb(0, 1'b0, 1'b0, 1'b0, 0);
        checks++; if (y8 !== 7'd20) begin failures++; $display("FAIL prio_slice actual=%0d expected=20", y8); end
        mb_done = 1'b1;
        reset_n = 1'b0;
        step();
        mb_done = 1'b0;
        checks++; if (v8 !== 1'b0) begin failures++; $display("FAIL rst_drop_valid actual=%0b expected=0", v8); end
        step();
        reset_n = 1'b1;
        checks++; if (v8 !== 1'b0) begin failures++; $display("FAIL rst_drop_valid2 actual=%0b expected=0", v8); end
        checks++; if (y8 !== 7'd0) begin failures++; $display("FAIL rst_drop_qpy actual=%0d expected=0", y8); end
    endtask

    task automatic test_chroma_offsets();
        logic [6:0] exp_cr8;
        logic [6:0] exp_cr10;
`ifdef SEPARATE_CR_OFFSET_EN
        exp_cr8 = 7'd36;
        exp_cr10 = 7'd48;
`else
        exp_cr8 = 7'd32;
        exp_cr10 = 7'd44;
`endif
        cb_qp_offset = 5'(-2);
        cr_qp_offset = 5'd4;
        load_slice(10, 0);
        do_mb(0, 1'b0, 1'b0, 1'b0, 0);
        checks++; if (cb8 !== 7'd32) begin failures++; $display("FAIL chroma_cb actual=%0d expected=32", cb8); end
        checks++; if (cr8 !== exp_cr8) begin failures++; $display("FAIL chroma_cr actual=%0d expected=%0d", cr8, exp_cr8); end
        checks++; if (cb10 !== 7'd44) begin failures++; $display("FAIL chroma_cb10 actual=%0d expected=44", cb10); end
        checks++; if (cr10 !== exp_cr10) begin failures++; $display("FAIL chroma_cr10 actual=%0d expected=%0d", cr10, exp_cr10); end
    endtask

    initial begin
        reset_n = 1'b0;
        slice_start = 1'b0;
        pic_init_qp_minus26 = '0;
        slice_qp_delta = '0;
        cb_qp_offset = '0;
        cr_qp_offset = '0;
        mb_qp_delta_vld = 1'b0;
        mb_qp_delta = '0;
        mb_done = 1'b0;
        mb_x = '0;
        left_avail = 1'b0;
        top_avail = 1'b0;
        test_reset();
        test_slice_latency();
        test_delta_wrap();
        test_high_bitdepth();
        test_row_buffer();
        test_back_to_back();
        test_priority_and_reset();
        test_chroma_offsets();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
